// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// instruction-word constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StFault
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to a
// fixed-latency BRAM and hands words to the decoder over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     code_q, code_d;
  logic [31:0]     ipc_q, ipc_d;
  logic            fault_q, fault_d;
  logic [31:0]     count_q, count_d;
  logic            kill_q, kill_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic handshake;
  logic misaligned;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    code_d     = code_q;
    ipc_d      = ipc_q;
    fault_d    = fault_q;
    count_d    = count_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;

    imem_en    = (state_q == StReq) & ~redirect_valid & ~rst;
    handshake  = (state_q == StHold) & inst_ready;
    misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

    unique case (state_q)
      StReq: begin
        if (imem_en) begin
          cnt_d   = CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        // rdata is only looked at on the counted cycle, so stale words never land
        if (cnt_q == CntLast) begin
          if (!kill_q && !redirect_valid) begin
            code_d  = imem_rdata;
            ipc_d   = pc_q;
            state_d = StHold;
          end else begin
            kill_d  = 1'b0;
            state_d = StReq;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (redirect_valid) kill_d = 1'b1;
        end
      end
      StHold: begin
        if (handshake) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_q + 32'(INST_BYTES);
          state_d = StReq;
        end
        if (redirect_valid) state_d = StReq;
      end
      StFault: ;
      default: state_d = StReq;
    endcase

    // A redirect overrides the sequential PC, including on a handshake cycle
    if (state_q != StFault && redirect_valid) begin
      pc_d = redirect_pc;
      if (misaligned) begin
        fault_d = 1'b1;
        kill_d  = 1'b0;
        state_d = StFault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      code_q  <= 32'h0;
      ipc_q   <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'h0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      count_q <= count_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == StHold);
  assign inst_code   = code_q;
  assign inst_pc     = ipc_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model of the fetch stage and a BRAM model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned MemLatency = 2;
  localparam logic [31:0] MemXor     = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fetch_count;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .MEM_LATENCY (MemLatency)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // BRAM model: each accepted request returns addr^MemXor exactly MemLatency cycles later
  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;
  req_t mq[$];

  // Fetch-stage model in terms of absolute due times rather than counters
  int unsigned cyc = 0;
  logic        chk_on = 1'b0;
  logic [31:0] m_pc;
  logic        m_busy, m_killed, m_held, m_fault;
  int unsigned m_due;
  logic [31:0] m_code, m_ipc, m_count;

  logic        s_en, s_valid, s_fault;
  logic [31:0] s_addr, s_code, s_pc, s_count;

  task automatic model_reset();
    m_pc     = 32'h0;
    m_busy   = 1'b0;
    m_killed = 1'b0;
    m_held   = 1'b0;
    m_fault  = 1'b0;
    m_due    = 0;
    m_code   = 32'h0;
    m_ipc    = 32'h0;
    m_count  = 32'h0;
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic e_en, hs, due;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
    while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
    if (mq.size() > 0 && mq[0].due == cyc) imem_rdata = mq[0].addr ^ MemXor;
    else imem_rdata = $urandom;
    #4;
    e_en    = !r && !m_fault && !m_busy && !m_held && !rv;
    s_en    = imem_en;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_code  = inst_code;
    s_pc    = inst_pc;
    s_fault = fault;
    s_count = fetch_count;
    if (chk_on) begin
      check("imem_en", {31'h0, s_en}, {31'h0, e_en});
      check("imem_addr", s_addr, m_pc);
      check("inst_valid", {31'h0, s_valid}, {31'h0, m_held});
      if (m_held) begin
        check("inst_code", s_code, m_code);
        check("inst_pc", s_pc, m_ipc);
      end
      check("fault", {31'h0, s_fault}, {31'h0, m_fault});
      check("fetch_count", s_count, m_count);
    end
    if (imem_en) mq.push_back('{due: cyc + MemLatency, addr: imem_addr});
    @(posedge clk);
    hs  = m_held && rdy;
    due = m_busy && (cyc == m_due);
    if (r) begin
      model_reset();
      chk_on = 1'b1;
    end else if (!m_fault) begin
      if (hs) m_count = m_count + 32'd1;
      if (rv && rp[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_held  = 1'b0;
        m_busy  = 1'b0;
        m_pc    = rp;
      end else if (rv) begin
        m_pc   = rp;
        m_held = 1'b0;
        if (due) begin
          m_busy   = 1'b0;
          m_killed = 1'b0;
        end else if (m_busy) begin
          m_killed = 1'b1;
        end
      end else begin
        if (hs) begin
          m_held = 1'b0;
          m_pc   = m_pc + 32'(INST_BYTES);
        end
        if (due) begin
          m_busy = 1'b0;
          if (!m_killed) begin
            m_held = 1'b1;
            m_code = m_pc ^ MemXor;
            m_ipc  = m_pc;
          end
          m_killed = 1'b0;
        end
        if (e_en) begin
          m_busy   = 1'b1;
          m_due    = cyc + MemLatency;
          m_killed = 1'b0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [31:0] rnd;
    model_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    imem_rdata = 32'h0;

    // 1: first fetch after reset, reset values of the output registers
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_en_c0", {31'h0, s_en}, 32'h1);
    check("t1_addr_c0", s_addr, 32'h0);
    check("t1_rst_code", s_code, 32'h0);
    check("t1_rst_pc", s_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_valid_c3", {31'h0, s_valid}, 32'h1);
    check("t1_code_c3", s_code, 32'hA5A5_0000);
    check("t1_pc_c3", s_pc, 32'h0);

    // 2: back-pressure at pc 4
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_en_addr4", {31'h0, s_en}, 32'h1);
    check("t2_addr4", s_addr, 32'h4);
    check("t2_count1", s_count, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("t2_hold_valid", {31'h0, s_valid}, 32'h1);
      check("t2_hold_pc", s_pc, 32'h4);
      check("t2_hold_code", s_code, 32'h4 ^ MemXor);
      check("t2_hold_en", {31'h0, s_en}, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_addr8", s_addr, 32'h8);
    check("t2_count2", s_count, 32'h2);

    // 3: redirect while the addr-8 request is in flight
    step(1'b0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_no_stale", {31'h0, s_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_en", {31'h0, s_en}, 32'h1);
    check("t3_addr", s_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_pc", s_pc, 32'h100);

    // 4: handshake at pc 0xC coincides with redirect to 0x40
    step(1'b0, 1'b1, 32'hC, 1'b1);
    check("t4_redir_no_en", {31'h0, s_en}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    check("t4_pc_c", s_pc, 32'hC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_addr40", s_addr, 32'h40);
    check("t4_count4", s_count, 32'h4);

    // 5: misaligned redirect, then recovery through reset
    step(1'b0, 1'b1, 32'h102, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_fault", {31'h0, s_fault}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      rnd = $urandom;
      step(1'b0, rnd[0], {rnd[31:2], 2'b00}, rnd[1]);
      check("t5_fault_no_en", {31'h0, s_en}, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_fault_clr", {31'h0, s_fault}, 32'h0);
    check("t5_restart_addr", s_addr, 32'h0);
    check("t5_restart_en", {31'h0, s_en}, 32'h1);

    // 6: reset while waiting, then PC wrap
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_addr0", s_addr, 32'h0);
    check("t6_en", {31'h0, s_en}, 32'h1);
    check("t6_count0", s_count, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_pc_top", s_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_wrap_addr", s_addr, 32'h0);
    check("t6_wrap_en", {31'h0, s_en}, 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, rdy;
      logic [31:0] rp;
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rnd = $urandom;
      rp  = {rnd[31:2], 2'b00};
      if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      step(r, rv, rp, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
